// File: rtl/pico_mips.sv
// rtl/pico_mips.sv - single-cycle MIPS-style core running a built-in 2-D affine transform
// Optional saturating ADD/ADDI arithmetic is selected with `define PICO_MIPS_SAT_EN.
module pico_mips #(
    parameter int N            = 8,
    parameter int MaxProgramSz = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic signed [N-1:0] in_bus,
    input  logic                io_handshake,
    output logic signed [N-1:0] out_bus
);

    localparam int PcW = $clog2(MaxProgramSz);

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_ADD   = 4'd1;
    localparam logic [3:0] OP_ADDI  = 4'd2;
    localparam logic [3:0] OP_MUL   = 4'd3;
    localparam logic [3:0] OP_MULI  = 4'd4;
    localparam logic [3:0] OP_IN    = 4'd5;
    localparam logic [3:0] OP_OUT   = 4'd6;
    localparam logic [3:0] OP_WAIT1 = 4'd7;
    localparam logic [3:0] OP_WAIT0 = 4'd8;
    localparam logic [3:0] OP_JMP   = 4'd9;

    function automatic logic [23:0] enc(input logic [3:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs, input logic [2:0] rt,
                                        input logic [7:0] imm);
        return {op, rd, rs, rt, 3'b000, imm};
    endfunction

    function automatic logic [23:0] rom(input logic [PcW-1:0] addr);
        case (int'(addr))
            0:       return enc(OP_WAIT1, 3'd0, 3'd0, 3'd0, 8'h00);
            1:       return enc(OP_IN,    3'd1, 3'd0, 3'd0, 8'h00);
            2:       return enc(OP_WAIT0, 3'd0, 3'd0, 3'd0, 8'h00);
            3:       return enc(OP_WAIT1, 3'd0, 3'd0, 3'd0, 8'h00);
            4:       return enc(OP_IN,    3'd2, 3'd0, 3'd0, 8'h00);
            5:       return enc(OP_WAIT0, 3'd0, 3'd0, 3'd0, 8'h00);
            6:       return enc(OP_MULI,  3'd3, 3'd1, 3'd0, 8'h60);
            7:       return enc(OP_MULI,  3'd4, 3'd2, 3'd0, 8'h40);
            8:       return enc(OP_ADD,   3'd3, 3'd3, 3'd4, 8'h00);
            9:       return enc(OP_ADDI,  3'd3, 3'd3, 3'd0, 8'h14);
            10:      return enc(OP_OUT,   3'd0, 3'd3, 3'd0, 8'h00);
            11:      return enc(OP_MULI,  3'd5, 3'd1, 3'd0, 8'hC0);
            12:      return enc(OP_MULI,  3'd6, 3'd2, 3'd0, 8'h60);
            13:      return enc(OP_ADD,   3'd5, 3'd5, 3'd6, 8'h00);
            14:      return enc(OP_ADDI,  3'd5, 3'd5, 3'd0, 8'hEC);
            15:      return enc(OP_WAIT1, 3'd0, 3'd0, 3'd0, 8'h00);
            16:      return enc(OP_OUT,   3'd0, 3'd5, 3'd0, 8'h00);
            17:      return enc(OP_WAIT0, 3'd0, 3'd0, 3'd0, 8'h00);
            18:      return enc(OP_JMP,   3'd0, 3'd0, 3'd0, 8'h00);
            default: return enc(OP_NOP,   3'd0, 3'd0, 3'd0, 8'h00);
        endcase
    endfunction

    logic        [PcW-1:0] pc;
    logic        [PcW-1:0] pc_inc;
    logic        [PcW-1:0] pc_next;
    logic signed [N-1:0]   regs [8];

    logic        [23:0]    instr;
    logic        [3:0]     op;
    logic        [2:0]     rd;
    logic        [2:0]     rs;
    logic        [2:0]     rt;
    logic signed [N-1:0]   imm_n;
    logic signed [N-1:0]   rs_val;
    logic signed [N-1:0]   rt_val;
    logic signed [N-1:0]   mul_b;
    logic signed [N-1:0]   add_b;
    logic signed [2*N-1:0] prod;
    logic signed [N-1:0]   frac;
    logic signed [N:0]     sum_w;
    logic signed [N-1:0]   sum_n;
    logic                  reg_we;
    logic                  out_we;
    logic signed [N-1:0]   wdata;
    logic                  unused_bits;

    always_comb begin
        instr  = rom(pc);
        op     = instr[23:20];
        rd     = instr[19:17];
        rs     = instr[16:14];
        rt     = instr[13:11];
        imm_n  = N'(signed'(instr[7:0]));
        rs_val = (rs == 3'd0) ? '0 : regs[rs];
        rt_val = (rt == 3'd0) ? '0 : regs[rt];
    end

    // Q0.(N-1) multiply: dropping the low N-1 bits of the product truncates toward -inf.
    always_comb begin
        mul_b = (op == OP_MULI) ? imm_n : rt_val;
        prod  = (2*N)'(rs_val) * (2*N)'(mul_b);
        frac  = prod[2*N-2:N-1];
    end

    always_comb begin
        add_b = (op == OP_ADDI) ? imm_n : rt_val;
        sum_w = (N+1)'(rs_val) + (N+1)'(add_b);
`ifdef PICO_MIPS_SAT_EN
        // Overflow when the extra sign bit disagrees with the N-bit sign.
        if (sum_w[N] != sum_w[N-1])
            sum_n = sum_w[N] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        else
            sum_n = sum_w[N-1:0];
`else
        sum_n = sum_w[N-1:0];
`endif
    end

    assign unused_bits = ^{instr[10:8], prod[2*N-1], prod[N-2:0], sum_w[N]};

    always_comb begin
        pc_inc  = (pc == PcW'(MaxProgramSz - 1)) ? '0 : pc + PcW'(1);
        pc_next = pc_inc;
        reg_we  = 1'b0;
        out_we  = 1'b0;
        wdata   = '0;
        case (op)
            OP_ADD, OP_ADDI: begin
                reg_we = 1'b1;
                wdata  = sum_n;
            end
            OP_MUL, OP_MULI: begin
                reg_we = 1'b1;
                wdata  = frac;
            end
            OP_IN: begin
                reg_we = 1'b1;
                wdata  = in_bus;
            end
            OP_OUT:   out_we = 1'b1;
            OP_WAIT1: if (!io_handshake) pc_next = pc;
            OP_WAIT0: if (io_handshake) pc_next = pc;
            OP_JMP:   pc_next = PcW'(instr[7:0]);
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc      <= '0;
            out_bus <= '0;
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else begin
            pc <= pc_next;
            if (reg_we && rd != 3'd0) regs[rd] <= wdata;
            if (out_we) out_bus <= rs_val;
        end
    end

endmodule

// File: tb/tb_pico_mips.sv
// tb/tb_pico_mips.sv - directed bench for pico_mips with a program-level reference model
module tb_pico_mips;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       io_handshake = 1'b0;
    logic [7:0] in_bus = 8'h00;
    logic [7:0] out_bus;

    int vectors = 0;
    int fails   = 0;

    always #5 clk = ~clk;

    pico_mips #(.N(8), .MaxProgramSz(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_bus       (in_bus),
        .io_handshake (io_handshake),
        .out_bus      (out_bus)
    );

    function automatic int sx8(input logic [7:0] v);
        logic signed [7:0] s;
        s = v;
        return int'(s);
    endfunction

    function automatic int add8(input int a, input int b);
        int s;
        s = a + b;
`ifdef PICO_MIPS_SAT_EN
        if (s > 127) return 127;
        if (s < -128) return -128;
        return s;
`else
        return sx8(s[7:0]);
`endif
    endfunction

    function automatic int q7(input int a, input int c);
        return (a * c) >>> 7;
    endfunction

    function automatic int calc_x2(input int x, input int y);
        return add8(add8(q7(x, 96), q7(y, 64)), 20);
    endfunction

    function automatic int calc_y2(input int x, input int y);
        return add8(add8(q7(x, -64), q7(y, 96)), -20);
    endfunction

    // Reference model: position in the program listing and the values it has captured.
    int  m_step = 0;
    int  m_x1 = 0;
    int  m_y1 = 0;
    int  m_out = 0;
    bit  started = 1'b0;

    always @(posedge clk) begin
        started = 1'b1;
        if (reset) begin
            m_step = 0;
            m_out  = 0;
        end else begin
            case (m_step)
                0, 3, 15: if (io_handshake) m_step = m_step + 1;
                2, 5, 17: if (!io_handshake) m_step = m_step + 1;
                1:  begin m_x1 = sx8(in_bus); m_step = 2; end
                4:  begin m_y1 = sx8(in_bus); m_step = 5; end
                10: begin m_out = calc_x2(m_x1, m_y1); m_step = 11; end
                16: begin m_out = calc_y2(m_x1, m_y1); m_step = 17; end
                18: m_step = 0;
                default: m_step = m_step + 1;
            endcase
        end
    end

    always @(negedge clk) begin
        logic [7:0] exp_out;
        if (started) begin
            exp_out = 8'(m_out);
            vectors++;
            if (out_bus !== exp_out) begin
                fails++;
                $display("FAIL cycle_out t=%0t out_bus=%h expected=%h", $time, out_bus, exp_out);
            end
        end
    end

    task automatic check_lit(input string name, input logic [7:0] exp);
        vectors++;
        if (out_bus !== exp) begin
            fails++;
            $display("FAIL %s out_bus=%h expected=%h", name, out_bus, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic x_phase(input logic [7:0] x);
        @(negedge clk);
        in_bus = x;
        io_handshake = 1'b1;
        cycles(3);
        io_handshake = 1'b0;
        cycles(3);
    endtask

    // y1 capture, x2 timing (6 cycles after release), y2 on third high phase, return to PC 0.
    task automatic y_phase(input logic [7:0] y, input logic [7:0] exp_x2,
                           input logic [7:0] exp_y2, input logic [7:0] prev);
        @(negedge clk);
        in_bus = y;
        io_handshake = 1'b1;
        cycles(3);
        io_handshake = 1'b0;
        cycles(5);
        check_lit("x2_not_yet", prev);
        cycles(1);
        check_lit("x2", exp_x2);
        cycles(6);
        check_lit("x2_held", exp_x2);
        io_handshake = 1'b1;
        cycles(1);
        check_lit("y2_not_yet", exp_x2);
        cycles(1);
        check_lit("y2", exp_y2);
        cycles(1);
        io_handshake = 1'b0;
        cycles(3);
    endtask

    initial begin
        reset = 1'b1;
        in_bus = 8'h5A;
        io_handshake = 1'b1;
        cycles(4);
        check_lit("reset", 8'h00);
        io_handshake = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_bus = 8'(i * 29 + 3);
            cycles(1);
        end
        check_lit("stalled_wait1", 8'h00);

        x_phase(8'hCE);
        y_phase(8'h8B, 8'hB3, 8'hAD, 8'h00);

        x_phase(8'h22);
        y_phase(8'h55, 8'h57, 8'h1A, 8'hAD);

        x_phase(8'h7F);
`ifdef PICO_MIPS_SAT_EN
        y_phase(8'h7F, 8'h7F, 8'h0B, 8'h1A);
`else
        y_phase(8'h7F, 8'hB2, 8'h0B, 8'h1A);
`endif

        x_phase(8'h40);
        @(negedge clk);
        reset = 1'b1;
        cycles(2);
        check_lit("reset_mid", 8'h00);
        reset = 1'b0;
        x_phase(8'hCE);
        y_phase(8'h8B, 8'hB3, 8'hAD, 8'h00);

        // Handshake held high across x1 capture: later in_bus values must be ignored.
        @(negedge clk);
        in_bus = 8'h22;
        io_handshake = 1'b1;
        cycles(2);
        for (int i = 0; i < 8; i++) begin
            in_bus = 8'(i * 37 + 1);
            cycles(1);
        end
        check_lit("hold_high", 8'hAD);
        io_handshake = 1'b0;
        cycles(3);
        y_phase(8'h55, 8'h57, 8'h1A, 8'hAD);

        cycles(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
